// File: rtl/mdom_wvb_hdr_builder_if.sv
// rtl/mdom_wvb_hdr_builder_if.sv - header FIFO write-side bundle for the waveform header builder
interface mdom_wvb_hdr_builder_if;
    logic [101:0] hdr_bundle;
    logic         hdr_wr_en;
    logic         hdr_full;

    modport master (
        output hdr_bundle,
        output hdr_wr_en,
        input  hdr_full
    );

    modport slave (
        input  hdr_bundle,
        input  hdr_wr_en,
        output hdr_full
    );
endinterface

// File: rtl/mdom_wvb_hdr_builder.sv
// rtl/mdom_wvb_hdr_builder.sv - per-segment waveform header builder for one mDOM ADC channel
module mdom_wvb_hdr_builder #(
    parameter int MAX_SEG_LEN = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [48:0]                   ltc,
    input  logic                          trig,
    input  logic                          trig_end,
    input  logic                          wr_en,
    input  logic [8:0]                    wr_addr,
    input  logic [1:0]                    trig_src_in,
    input  logic                          cnst_run_in,
    input  logic [4:0]                    pre_conf_in,
    input  logic                          sync_rdy_in,
    input  logic [18:0]                   bsum_in,
    input  logic [2:0]                    bsum_len_sel_in,
    input  logic                          bsum_valid_in,
    input  logic                          local_coinc_in,
    mdom_wvb_hdr_builder_if.master        hdr,
    output logic                          busy,
    output logic                          hdr_overflow
);

    localparam logic [9:0] SEG_MAX = 10'(MAX_SEG_LEN);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    rst_sync_q;
    logic          rst_ni;

    logic [48:0]   evt_ltc_q;
    logic [8:0]    start_q;
    logic [1:0]    trig_src_q;
    logic          cnst_run_q;
    logic [4:0]    pre_conf_q;
    logic          sync_rdy_q;
    logic [18:0]   bsum_q;
    logic [2:0]    bsum_len_sel_q;
    logic          bsum_valid_q;
    logic          coinc_q;
    logic          cont_q;
    logic [9:0]    seg_cnt_q;
    logic          new_seg_q;

    logic          pend_valid_q;
    logic [101:0]  pend_hdr_q;
    logic          wr_fire;

    logic          idle_open, active_wr, seg_open, close;
    logic [48:0]   eff_ltc;
    logic [8:0]    eff_start;
    logic [9:0]    eff_cnt;
    logic          eff_coinc, eff_cont;
    logic [101:0]  close_hdr;

    // Reset asserts immediately but releases two clocks later, clean of the clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_ni = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        idle_open = (state_q == IDLE) && trig && wr_en;
        active_wr = idle_open || ((state_q == CAPTURE) && wr_en);
        // A write right after a length-limit close starts the follow-on segment.
        seg_open  = idle_open || ((state_q == CAPTURE) && wr_en && new_seg_q);
        eff_ltc   = seg_open ? ltc : evt_ltc_q;
        eff_start = seg_open ? wr_addr : start_q;
        eff_cnt   = seg_open ? 10'd1 : seg_cnt_q + 10'd1;
        eff_coinc = seg_open ? local_coinc_in : (coinc_q | local_coinc_in);
        eff_cont  = idle_open ? 1'b0 : (seg_open ? 1'b1 : cont_q);
        close     = active_wr && (trig_end || (eff_cnt == SEG_MAX));
        close_hdr = idle_open
            ? {eff_cont, ~trig_end, eff_coinc, bsum_valid_in, bsum_len_sel_in, bsum_in,
               sync_rdy_in, pre_conf_in, cnst_run_in, trig_src_in, wr_addr, eff_start, eff_ltc}
            : {eff_cont, ~trig_end, eff_coinc, bsum_valid_q, bsum_len_sel_q, bsum_q,
               sync_rdy_q, pre_conf_q, cnst_run_q, trig_src_q, wr_addr, eff_start, eff_ltc};
        if (active_wr) begin
            state_d = (close && trig_end) ? IDLE : CAPTURE;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_ltc_q      <= '0;
            start_q        <= '0;
            trig_src_q     <= '0;
            cnst_run_q     <= 1'b0;
            pre_conf_q     <= '0;
            sync_rdy_q     <= 1'b0;
            bsum_q         <= '0;
            bsum_len_sel_q <= '0;
            bsum_valid_q   <= 1'b0;
            coinc_q        <= 1'b0;
            cont_q         <= 1'b0;
            seg_cnt_q      <= '0;
            new_seg_q      <= 1'b0;
        end else if (active_wr) begin
            evt_ltc_q <= eff_ltc;
            start_q   <= eff_start;
            seg_cnt_q <= eff_cnt;
            coinc_q   <= eff_coinc;
            cont_q    <= eff_cont;
            new_seg_q <= close && !trig_end;
            if (idle_open) begin
                trig_src_q     <= trig_src_in;
                cnst_run_q     <= cnst_run_in;
                pre_conf_q     <= pre_conf_in;
                sync_rdy_q     <= sync_rdy_in;
                bsum_q         <= bsum_in;
                bsum_len_sel_q <= bsum_len_sel_in;
                bsum_valid_q   <= bsum_valid_in;
            end
        end
    end

    assign wr_fire = pend_valid_q && !hdr.hdr_full;

    // A slot being drained this cycle can accept the next close without a drop.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= 1'b0;
            pend_hdr_q   <= '0;
            hdr_overflow <= 1'b0;
        end else if (close) begin
            if (!pend_valid_q || wr_fire) begin
                pend_hdr_q   <= close_hdr;
                pend_valid_q <= 1'b1;
            end else begin
                hdr_overflow <= 1'b1;
            end
        end else if (wr_fire) begin
            pend_valid_q <= 1'b0;
        end
    end

    assign hdr.hdr_wr_en  = wr_fire;
    assign hdr.hdr_bundle = pend_hdr_q;
    assign busy           = (state_q != IDLE) || pend_valid_q;

endmodule

// File: tb/tb_mdom_wvb_hdr_builder.sv
// tb/tb_mdom_wvb_hdr_builder.sv - scoreboard bench for mdom_wvb_hdr_builder
module tb_mdom_wvb_hdr_builder;
    localparam int MAXL = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [48:0] ltc;
    logic        trig, trig_end, wr_en;
    logic [8:0]  wr_addr;
    logic [1:0]  trig_src_in;
    logic        cnst_run_in;
    logic [4:0]  pre_conf_in;
    logic        sync_rdy_in;
    logic [18:0] bsum_in;
    logic [2:0]  bsum_len_sel_in;
    logic        bsum_valid_in;
    logic        local_coinc_in;
    logic        busy, hdr_overflow;

    mdom_wvb_hdr_builder_if hif();

    mdom_wvb_hdr_builder #(.MAX_SEG_LEN(MAXL)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ltc             (ltc),
        .trig            (trig),
        .trig_end        (trig_end),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .trig_src_in     (trig_src_in),
        .cnst_run_in     (cnst_run_in),
        .pre_conf_in     (pre_conf_in),
        .sync_rdy_in     (sync_rdy_in),
        .bsum_in         (bsum_in),
        .bsum_len_sel_in (bsum_len_sel_in),
        .bsum_valid_in   (bsum_valid_in),
        .local_coinc_in  (local_coinc_in),
        .hdr             (hif.master),
        .busy            (busy),
        .hdr_overflow    (hdr_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [101:0] bundle;
        int           due;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int          gaps  [1024];
    int          s_off [1024];
    int          s_addr[1024];
    logic [48:0] s_ltc [1024];
    bit          s_co  [1024];

    logic [1:0]  f_ts;
    logic        f_cr;
    logic [4:0]  f_pc;
    logic        f_sr;
    logic [18:0] f_bs;
    logic [2:0]  f_bl;
    logic        f_bv;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (hif.hdr_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hdr actual=%0h required=none", hif.hdr_bundle);
            end else begin
                mon_e = exp_q.pop_front();
                check("hdr_bundle", hif.hdr_bundle, mon_e.bundle);
                if (mon_e.due >= 0) check("hdr_latency_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ltc = ltc + 49'd1;
    endtask

    task automatic rand_inputs();
        trig_src_in     = 2'($urandom);
        cnst_run_in     = 1'($urandom);
        pre_conf_in     = 5'($urandom);
        sync_rdy_in     = 1'($urandom);
        bsum_in         = 19'($urandom);
        bsum_len_sel_in = 3'($urandom);
        bsum_valid_in   = 1'($urandom);
    endtask

    task automatic new_fields();
        f_ts = 2'($urandom);
        f_cr = 1'($urandom);
        f_pc = 5'($urandom);
        f_sr = 1'($urandom);
        f_bs = 19'($urandom);
        f_bl = 3'($urandom);
        f_bv = 1'($urandom);
    endtask

    // Reference: cut the sample list into MAXL-sized chunks, one header per chunk.
    task automatic model(input int n, input bit timed, input int c0);
        for (int k = 0; k < n; k += MAXL) begin
            int   last;
            bit   co, cont, part;
            exp_t e;
            last = (k + MAXL < n) ? k + MAXL - 1 : n - 1;
            co = 1'b0;
            for (int j = k; j <= last; j++) co |= s_co[j];
            cont = (k > 0);
            part = (last != n - 1);
            e.bundle = {cont, part, co, f_bv, f_bl, f_bs, f_sr, f_pc, f_cr, f_ts,
                        9'(s_addr[last]), 9'(s_addr[k]), s_ltc[k]};
            e.due = timed ? c0 + s_off[last] + 1 : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_wave(input int n, input int a0, input int gmax, input int cmode,
                              input bit with_end, input bit do_model, input bit timed);
        int c0, acc;
        new_fields();
        acc = 0;
        for (int i = 0; i < n; i++) begin
            gaps[i] = (i == 0 || gmax == 0) ? 0
                    : (($urandom % 4 == 0) ? int'($urandom_range(1, gmax)) : 0);
            acc += gaps[i];
            s_off[i]  = acc + i;
            s_addr[i] = (a0 + i) % 512;
            s_ltc[i]  = ltc + 49'(s_off[i]);
            s_co[i]   = (cmode == 0) ? ($urandom % 16 == 0) : ((cmode == 1) ? (i == 300) : 1'b0);
        end
        c0 = cyc;
        if (do_model) model(n, timed, c0);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                wr_en = 1'b0;
                trig = 1'($urandom % 8 == 0);
                trig_end = 1'($urandom % 8 == 0);
                local_coinc_in = 1'b0;
                wr_addr = 9'($urandom);
                rand_inputs();
                step();
            end
            wr_en          = 1'b1;
            wr_addr        = 9'(s_addr[i]);
            trig           = (i == 0) || ($urandom % 16 == 0);
            trig_end       = with_end && (i == n - 1);
            local_coinc_in = s_co[i];
            if (i == 0) begin
                trig_src_in = f_ts; cnst_run_in = f_cr; pre_conf_in = f_pc; sync_rdy_in = f_sr;
                bsum_in = f_bs; bsum_len_sel_in = f_bl; bsum_valid_in = f_bv;
            end else begin
                rand_inputs();
            end
            step();
        end
        wr_en = 1'b0; trig = 1'b0; trig_end = 1'b0; local_coinc_in = 1'b0;
    endtask

    // Idle-state noise that must never open a waveform: trig without wr_en, writes without trig.
    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            wr_en = 1'($urandom % 4 == 0);
            trig = wr_en ? 1'b0 : 1'($urandom);
            trig_end = 1'($urandom);
            wr_addr = 9'($urandom);
            local_coinc_in = 1'($urandom);
            rand_inputs();
            step();
        end
        wr_en = 1'b0; trig = 1'b0; trig_end = 1'b0; local_coinc_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_hdr_wr_en"}, hif.hdr_wr_en, 0);
        check({tag, "_hdr_bundle"}, hif.hdr_bundle, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overflow"}, hdr_overflow, 0);
    endtask

    initial begin
        rst_n = 1'b0; ltc = {17'($urandom), 32'($urandom)};
        trig = 0; trig_end = 0; wr_en = 0; wr_addr = 0; local_coinc_in = 0;
        rand_inputs();
        hif.hdr_full = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        step();
        rst_n = 1'b1;
        repeat (3) step();

        ltc = 49'h1_0000_0000;
        drive_wave(20, 10, 0, 2, 1'b1, 1'b1, 1'b1);
        idle(4);
        @(negedge clk);
        check("busy_after_single", busy, 0);
        step();

        drive_wave(600, 500, 0, 1, 1'b1, 1'b1, 1'b1);
        idle(4);
        drive_wave(1, int'($urandom % 512), 0, 0, 1'b1, 1'b1, 1'b1);
        idle(3);
        drive_wave(256, int'($urandom % 512), 2, 0, 1'b1, 1'b1, 1'b1);
        idle(3);
        drive_wave(257, int'($urandom % 512), 0, 0, 1'b1, 1'b1, 1'b1);
        idle(3);

        hif.hdr_full = 1'b1;
        drive_wave(20, int'($urandom % 512), 2, 0, 1'b1, 1'b1, 1'b0);
        check("hold_queue_depth", exp_q.size(), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_wr_en", hif.hdr_wr_en, 0);
            check("hold_busy", busy, 1);
            if (exp_q.size() > 0) check("hold_bundle", hif.hdr_bundle, exp_q[0].bundle);
            step();
        end
        hif.hdr_full = 1'b0;
        @(negedge clk);
        check("release_wr_en", hif.hdr_wr_en, 1);
        step();
        idle(3);

        hif.hdr_full = 1'b1;
        drive_wave(10, int'($urandom % 512), 1, 0, 1'b1, 1'b1, 1'b0);
        idle(2);
        drive_wave(5, int'($urandom % 512), 0, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("overflow_set", hdr_overflow, 1);
        check("overflow_busy", busy, 1);
        step();
        hif.hdr_full = 1'b0;
        idle(5);
        @(negedge clk);
        check("overflow_sticky", hdr_overflow, 1);
        check("overflow_queue_drained", exp_q.size(), 0);
        step();
        rst_n = 1'b0;
        step();
        check_all_zero("ovf_reset");
        step();
        rst_n = 1'b1;
        repeat (3) step();

        hif.hdr_full = 1'b1;
        drive_wave(300, int'($urandom % 512), 1, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        hif.hdr_full = 1'b0;
        check_all_zero("midcap_reset");
        step();
        rst_n = 1'b1;
        repeat (3) step();
        idle(5);
        drive_wave(30, int'($urandom % 512), 1, 0, 1'b1, 1'b1, 1'b1);
        idle(3);

        for (int r = 0; r < 10; r++) begin
            drive_wave(int'($urandom_range(1, 700)), int'($urandom % 512), 3, 0, 1'b1, 1'b1, 1'b1);
            idle(int'($urandom_range(2, 6)));
        end

        for (int t = 0; t < 50 && exp_q.size() > 0; t++) step();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
